hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller for the 5-stage integer core. It generates the stall and flush controls that sequence the IF/ID/EXE/MEM pipeline registers around the forwarding network, keeping a register scoreboard for the single outstanding long-latency (mul/div) operation. It also arbitrates the shared WB register-file write port between the pipeline and that unit. When starvation threatens, it steals a WB slot by freezing the pipeline.

## Interface
- STARVE_LIMIT, 4: consecutive denied cycles of div_wb_req before a WB slot is stolen (1..15).
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- rs1_id, rs2_id  in  5 each  ID source registers
- rs1_used_id, rs2_used_id  in  1 each  source actually read by the ID instruction
- rd_id  in  5  ID destination register
- reg_write_id  in  1  ID instruction writes rd_id
- long_op_id  in  1  ID instruction is a mul/div
- rd_exe  in  5  EXE destination register
- mem_read_exe, reg_write_exe  in  1 each  EXE is a load / writes rd_exe
- div_issue  in  1  long op leaves EXE into the mul/div unit this cycle
- div_rd  in  5  destination of the issuing long op
- div_busy  in  1  mul/div unit occupied
- div_wb_req  in  1  mul/div result waiting for the WB port
- div_wb_rd  in  5  destination of the waiting result
- reg_write_wb  in  1  WB-stage instruction writes the register file this cycle
- branch_taken_exe  in  1  EXE redirects the PC
- dmem_stall  in  1  data memory not ready
- stall_if, stall_id, stall_exe, stall_mem  out  1 each  hold PC / IF-ID / ID-EXE / EXE-MEM registers
- flush_id, flush_exe, flush_wb  out  1 each  load a bubble into IF-ID / ID-EXE / MEM-WB
- div_wb_grant  out  1  mul/div result owns the WB port this cycle
- pending  out  32  scoreboard; bit r set = r awaits a mul/div result
- stall_count  out  32  wrapping count of cycles with stall_id=1

## Operation
- Scoreboard set: div_issue & rd≠0 & ~stall_exe sets pending[div_rd].
- Scoreboard clear: div_wb_grant clears pending[div_wb_rd].
- Set and clear of the same bit in one cycle: set wins. pending[0] is always 0.
- ID hazard (H):
  - load-use: mem_read_exe & reg_write_exe & rd_exe≠0 & (rs1_used_id&rs1_id==rd_exe | rs2_used_id&rs2_id==rd_exe)
  - RAW on pending: a used rs with pending[rs]=1
  - WAW: reg_write_id & rd_id≠0 & pending[rd_id]
  - structural: long_op_id & (div_busy | div_issue)
- WB arbiter FSM:
  - IDLE: div_wb_req & ~reg_write_wb → grant, stay IDLE. div_wb_req & reg_write_wb → WAIT, cnt=1.
  - WAIT: grant when ~reg_write_wb → IDLE. Otherwise cnt++; cnt==STARVE_LIMIT → STEAL.
  - STEAL (one cycle): stall_if/id/exe/mem=1, flush_wb=1, no grant → GRANT.
  - GRANT: reg_write_wb is 0 by construction; grant → IDLE.
  - div_wb_req deasserting in WAIT → IDLE.
- Control priority per cycle (highest first):
  - dmem_stall: all four stalls=1, flush_wb=1, no other flush. The FSM still runs, but it does not enter STEAL; the counter saturates at STARVE_LIMIT.
  - FSM in STEAL: as above.
  - branch_taken_exe: flush_id=flush_exe=1, H ignored.
  - H: stall_if=stall_id=1, flush_exe=1.
  - else all 0.
- stall_count increments on every cycle with stall_id=1, from any cause; wraps 0xFFFFFFFF→0.

## Timing
- All stall/flush/grant outputs are combinational from inputs and current state within the cycle. pending, FSM, cnt and stall_count update at posedge clk.
- Load-use costs exactly one bubble; RAW-on-pending stalls until the cycle after the clearing grant.
- Worst-case grant latency from div_wb_req rise: STARVE_LIMIT+2 cycles absent dmem_stall.
- Reset (any cycle, including mid-STEAL or mid-WAIT) sets pending=0, FSM=IDLE, cnt=0, stall_count=0. While reset=1 all stall/flush/grant outputs are 0.

## Test plan
- Load x5 in EXE, ID add reads x5 → stall_if=stall_id=flush_exe=1 for one cycle; stall_count=1.
- div_issue div_rd=7; ID reads x7 → stall until grant with div_wb_rd=7; pending[7] clears the next cycle, stall drops.
- div_wb_req held with reg_write_wb=1 continuously, STARVE_LIMIT=4 → STEAL on the 5th request cycle (4 counted WAIT cycles), grant on the 6th.
- Same-cycle div_issue rd=3 and grant rd=3 → pending[3]=1 afterward.
- branch_taken_exe concurrent with load-use → flush_id=flush_exe=1, stall_id=0. With dmem_stall also high → only the stalls and flush_wb assert.
- reset asserted during STEAL → next cycle FSM IDLE, pending=0, all outputs 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall/flush sequencing, mul/div register scoreboard,
// and WB write-port arbitration with starvation-driven slot stealing.
module hazard_ctrl #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [4:0]  i_rs1_id,
    input  logic [4:0]  i_rs2_id,
    input  logic        i_rs1_used_id,
    input  logic        i_rs2_used_id,
    input  logic [4:0]  i_rd_id,
    input  logic        i_reg_write_id,
    input  logic        i_long_op_id,
    input  logic [4:0]  i_rd_exe,
    input  logic        i_mem_read_exe,
    input  logic        i_reg_write_exe,
    input  logic        i_div_issue,
    input  logic [4:0]  i_div_rd,
    input  logic        i_div_busy,
    input  logic        i_div_wb_req,
    input  logic [4:0]  i_div_wb_rd,
    input  logic        i_reg_write_wb,
    input  logic        i_branch_taken_exe,
    input  logic        i_dmem_stall,
    output logic        o_stall_if,
    output logic        o_stall_id,
    output logic        o_stall_exe,
    output logic        o_stall_mem,
    output logic        o_flush_id,
    output logic        o_flush_exe,
    output logic        o_flush_wb,
    output logic        o_div_wb_grant,
    output logic [31:0] o_pending,
    output logic [31:0] o_stall_count
);

    localparam logic [4:0] LimitC = 5'(STARVE_LIMIT);

    typedef enum logic [1:0] {StIdle, StWait, StSteal, StGrant} arb_state_e;

    arb_state_e  r_state;
    arb_state_e  w_state_next;
    logic [4:0]  r_cnt;
    logic [4:0]  w_cnt_next;
    logic [4:0]  w_cnt_base;
    logic [4:0]  w_cnt_inc;
    logic [4:0]  w_cnt_sat;
    logic        w_grant_raw;
    logic        w_steal;

    logic [31:0] r_pending;
    logic [31:0] w_pending_next;
    logic [31:0] w_set_mask;
    logic [31:0] w_clr_mask;
    logic [31:0] r_stall_count;

    logic        w_load_use;
    logic        w_raw;
    logic        w_waw;
    logic        w_struct;
    logic        w_hazard;

    // Denied-cycle count: a fresh denial out of IDLE counts as the first one.
    assign w_cnt_base = (r_state == StWait) ? r_cnt : 5'd0;
    assign w_cnt_inc  = w_cnt_base + 5'd1;
    assign w_cnt_sat  = (w_cnt_inc >= LimitC) ? LimitC : w_cnt_inc;
    assign w_steal    = (r_state == StSteal);

    // WB arbiter next-state, starvation counter and raw grant.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_grant_raw  = 1'b0;
        unique case (r_state)
            StIdle, StWait: begin
                if (!i_div_wb_req) begin
                    w_state_next = StIdle;
                    w_cnt_next   = 5'd0;
                end else if (!i_reg_write_wb) begin
                    w_grant_raw  = 1'b1;
                    w_state_next = StIdle;
                    w_cnt_next   = 5'd0;
                end else begin
                    // A data-memory stall holds off the steal; the count just saturates.
                    w_cnt_next   = w_cnt_sat;
                    w_state_next = (w_cnt_sat >= LimitC && !i_dmem_stall) ? StSteal : StWait;
                end
            end
            StSteal: begin
                w_state_next = StGrant;
                w_cnt_next   = 5'd0;
            end
            StGrant: begin
                // The stolen slot leaves WB empty, so the result can always write now.
                w_grant_raw  = i_div_wb_req;
                w_state_next = StIdle;
                w_cnt_next   = 5'd0;
            end
            default: begin
                w_state_next = StIdle;
                w_cnt_next   = 5'd0;
            end
        endcase
    end

    // ID-stage hazard detection against EXE load, scoreboard and the mul/div unit.
    always_comb begin
        w_load_use = i_mem_read_exe && i_reg_write_exe && (i_rd_exe != 5'd0) &&
                     ((i_rs1_used_id && (i_rs1_id == i_rd_exe)) ||
                      (i_rs2_used_id && (i_rs2_id == i_rd_exe)));
        w_raw      = (i_rs1_used_id && r_pending[i_rs1_id]) ||
                     (i_rs2_used_id && r_pending[i_rs2_id]);
        w_waw      = i_reg_write_id && (i_rd_id != 5'd0) && r_pending[i_rd_id];
        w_struct   = i_long_op_id && (i_div_busy || i_div_issue);
        w_hazard   = w_load_use || w_raw || w_waw || w_struct;
    end

    // Prioritised stall/flush/grant outputs; everything is quiet while in reset.
    always_comb begin
        o_stall_if     = 1'b0;
        o_stall_id     = 1'b0;
        o_stall_exe    = 1'b0;
        o_stall_mem    = 1'b0;
        o_flush_id     = 1'b0;
        o_flush_exe    = 1'b0;
        o_flush_wb     = 1'b0;
        o_div_wb_grant = 1'b0;
        if (!i_reset) begin
            o_div_wb_grant = w_grant_raw;
            if (i_dmem_stall || w_steal) begin
                o_stall_if  = 1'b1;
                o_stall_id  = 1'b1;
                o_stall_exe = 1'b1;
                o_stall_mem = 1'b1;
                o_flush_wb  = 1'b1;
            end else if (i_branch_taken_exe) begin
                o_flush_id  = 1'b1;
                o_flush_exe = 1'b1;
            end else if (w_hazard) begin
                o_stall_if  = 1'b1;
                o_stall_id  = 1'b1;
                o_flush_exe = 1'b1;
            end
        end
    end

    // Scoreboard next value: set wins over clear, x0 never pends.
    always_comb begin
        w_set_mask = 32'd0;
        w_clr_mask = 32'd0;
        if (i_div_issue && (i_div_rd != 5'd0) && !o_stall_exe) begin
            w_set_mask = 32'd1 << i_div_rd;
        end
        if (o_div_wb_grant) begin
            w_clr_mask = 32'd1 << i_div_wb_rd;
        end
        w_pending_next    = (r_pending & ~w_clr_mask) | w_set_mask;
        w_pending_next[0] = 1'b0;
    end

    // State registers: arbiter, scoreboard and stall counter.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= StIdle;
            r_cnt         <= 5'd0;
            r_pending     <= 32'd0;
            r_stall_count <= 32'd0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_pending <= w_pending_next;
            if (o_stall_id) begin
                r_stall_count <= r_stall_count + 32'd1;
            end
        end
    end

    assign o_pending     = r_pending;
    assign o_stall_count = r_stall_count;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: each driven cycle pushes its expected controls,
// scoreboard and stall count; the monitor pops and compares on the falling edge.
module tb_hazard_ctrl;

    localparam logic [7:0] C_NONE = 8'h00;
    localparam logic [7:0] C_HAZ  = 8'hC4;  // stall_if, stall_id, flush_exe
    localparam logic [7:0] C_FRZ  = 8'hF2;  // all stalls, flush_wb
    localparam logic [7:0] C_BR   = 8'h0C;  // flush_id, flush_exe
    localparam logic [7:0] C_GNT  = 8'h01;

    logic        clk;
    logic        i_reset;
    logic [4:0]  i_rs1_id, i_rs2_id, i_rd_id, i_rd_exe, i_div_rd, i_div_wb_rd;
    logic        i_rs1_used_id, i_rs2_used_id, i_reg_write_id, i_long_op_id;
    logic        i_mem_read_exe, i_reg_write_exe, i_div_issue, i_div_busy;
    logic        i_div_wb_req, i_reg_write_wb, i_branch_taken_exe, i_dmem_stall;
    logic        o_stall_if, o_stall_id, o_stall_exe, o_stall_mem;
    logic        o_flush_id, o_flush_exe, o_flush_wb, o_div_wb_grant;
    logic [31:0] o_pending, o_stall_count;

    typedef struct {
        string       tag;
        logic [7:0]  ctl;
        logic [31:0] pend;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [31:0] exp_cnt = 32'd0;

    hazard_ctrl #(.STARVE_LIMIT(4)) dut (
        .i_clk              (clk),
        .i_reset            (i_reset),
        .i_rs1_id           (i_rs1_id),
        .i_rs2_id           (i_rs2_id),
        .i_rs1_used_id      (i_rs1_used_id),
        .i_rs2_used_id      (i_rs2_used_id),
        .i_rd_id            (i_rd_id),
        .i_reg_write_id     (i_reg_write_id),
        .i_long_op_id       (i_long_op_id),
        .i_rd_exe           (i_rd_exe),
        .i_mem_read_exe     (i_mem_read_exe),
        .i_reg_write_exe    (i_reg_write_exe),
        .i_div_issue        (i_div_issue),
        .i_div_rd           (i_div_rd),
        .i_div_busy         (i_div_busy),
        .i_div_wb_req       (i_div_wb_req),
        .i_div_wb_rd        (i_div_wb_rd),
        .i_reg_write_wb     (i_reg_write_wb),
        .i_branch_taken_exe (i_branch_taken_exe),
        .i_dmem_stall       (i_dmem_stall),
        .o_stall_if         (o_stall_if),
        .o_stall_id         (o_stall_id),
        .o_stall_exe        (o_stall_exe),
        .o_stall_mem        (o_stall_mem),
        .o_flush_id         (o_flush_id),
        .o_flush_exe        (o_flush_exe),
        .o_flush_wb         (o_flush_wb),
        .o_div_wb_grant     (o_div_wb_grant),
        .o_pending          (o_pending),
        .o_stall_count      (o_stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pb(input int r);
        logic [31:0] one;
        one = 32'd1;
        return one << r;
    endfunction

    task automatic clr_in();
        i_rs1_id = 5'd0; i_rs2_id = 5'd0; i_rd_id = 5'd0; i_rd_exe = 5'd0;
        i_div_rd = 5'd0; i_div_wb_rd = 5'd0;
        i_rs1_used_id = 1'b0; i_rs2_used_id = 1'b0; i_reg_write_id = 1'b0;
        i_long_op_id = 1'b0; i_mem_read_exe = 1'b0; i_reg_write_exe = 1'b0;
        i_div_issue = 1'b0; i_div_busy = 1'b0; i_div_wb_req = 1'b0;
        i_reg_write_wb = 1'b0; i_branch_taken_exe = 1'b0; i_dmem_stall = 1'b0;
    endtask

    // Load of x5 in EXE while the ID instruction reads x5 through rs1.
    task automatic load_use5();
        i_mem_read_exe = 1'b1; i_reg_write_exe = 1'b1; i_rd_exe = 5'd5;
        i_rs1_id = 5'd5; i_rs1_used_id = 1'b1;
    endtask

    task automatic req(input logic [4:0] rd, input logic wb_busy);
        i_div_wb_req = 1'b1; i_div_wb_rd = rd; i_reg_write_wb = wb_busy;
    endtask

    // Push the expectation for the cycle just driven, then advance to the next drive point.
    task automatic cyc(input string tag, input logic [7:0] ctl, input logic [31:0] pend);
        exp_t e;
        e.tag = tag; e.ctl = ctl; e.pend = pend; e.cnt = exp_cnt;
        sb.push_back(e);
        if (i_reset) exp_cnt = 32'd0;
        else if (ctl[6]) exp_cnt = exp_cnt + 32'd1;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check_val({e.tag, ".ctl"}, {24'd0, o_stall_if, o_stall_id, o_stall_exe, o_stall_mem,
                      o_flush_id, o_flush_exe, o_flush_wb, o_div_wb_grant}, {24'd0, e.ctl});
            check_val({e.tag, ".pend"}, o_pending, e.pend);
            check_val({e.tag, ".scnt"}, o_stall_count, e.cnt);
        end
    end

    initial begin
        int waited;
        i_reset = 1'b1;
        clr_in();
        @(posedge clk);
        #1;

        // Reset: outputs quiet even with a load-use pattern present.
        load_use5();                                         cyc("rst0", C_NONE, 0);
        cyc("rst1", C_NONE, 0);
        i_reset = 1'b0;

        // Load-use: one bubble, then neutral variants.
        clr_in(); load_use5();                               cyc("lu", C_HAZ, 0);
        clr_in(); i_rs1_id = 5; i_rs1_used_id = 1;           cyc("lu_done", C_NONE, 0);
        clr_in(); load_use5(); i_rs1_id = 6; i_rs2_id = 5;   cyc("lu_rs2_unused", C_NONE, 0);
        clr_in(); load_use5(); i_rd_exe = 0; i_rs1_id = 0;   cyc("lu_x0", C_NONE, 0);
        clr_in(); load_use5(); i_reg_write_exe = 0;          cyc("lu_nowr", C_NONE, 0);

        // Long op to x7: RAW, structural and WAW stalls until the clearing grant.
        clr_in(); i_div_issue = 1; i_div_rd = 7;             cyc("div_iss", C_NONE, 0);
        clr_in(); i_div_busy = 1; i_rs2_id = 7; i_rs2_used_id = 1;
                                                             cyc("raw", C_HAZ, pb(7));
        clr_in(); i_div_busy = 1; i_long_op_id = 1;          cyc("struct", C_HAZ, pb(7));
        clr_in(); i_reg_write_id = 1; i_rd_id = 7;           cyc("waw", C_HAZ, pb(7));
        clr_in(); i_div_busy = 1; i_rs2_id = 7; i_rs2_used_id = 1; req(7, 0);
                                                             cyc("raw_gnt", C_HAZ | C_GNT, pb(7));
        clr_in(); i_rs2_id = 7; i_rs2_used_id = 1;           cyc("raw_clr", C_NONE, 0);
        clr_in(); i_long_op_id = 1; i_div_issue = 1;         cyc("struct_iss", C_HAZ, 0);
        clr_in();                                            cyc("idle0", C_NONE, 0);

        // Starvation: 4 denied cycles, STEAL on the 5th, grant on the 6th.
        clr_in(); i_div_issue = 1; i_div_rd = 9;             cyc("iss9", C_NONE, 0);
        clr_in(); req(9, 1);                                 cyc("st_w1", C_NONE, pb(9));
        cyc("st_w2", C_NONE, pb(9));
        cyc("st_w3", C_NONE, pb(9));
        cyc("st_w4", C_NONE, pb(9));
        cyc("st_steal", C_FRZ, pb(9));
        clr_in(); req(9, 0);                                 cyc("st_gnt", C_GNT, pb(9));
        clr_in();                                            cyc("st_done", C_NONE, 0);

        // Same-cycle set and clear of x3: set wins. Issue under a freeze is dropped.
        clr_in(); i_div_issue = 1; i_div_rd = 3;             cyc("iss3", C_NONE, 0);
        clr_in(); i_div_issue = 1; i_div_rd = 3; req(3, 0);  cyc("setclr3", C_GNT, pb(3));
        clr_in();                                            cyc("kept3", C_NONE, pb(3));
        clr_in(); req(3, 0);                                 cyc("clr3", C_GNT, pb(3));
        clr_in(); i_div_issue = 1; i_div_rd = 4; i_dmem_stall = 1;
                                                             cyc("iss_frz", C_FRZ, 0);
        clr_in();                                            cyc("no_set4", C_NONE, 0);

        // Branch beats load-use; data-memory stall beats branch.
        clr_in(); load_use5(); i_branch_taken_exe = 1;       cyc("br_lu", C_BR, 0);
        i_dmem_stall = 1;                                    cyc("dm_br_lu", C_FRZ, 0);

        // Denied cycles under dmem_stall saturate the count; steal follows once it drops.
        clr_in(); req(2, 1); i_dmem_stall = 1;
        for (int i = 0; i < 6; i++) cyc("dm_wait", C_FRZ, 0);
        i_dmem_stall = 0;                                    cyc("dm_post", C_NONE, 0);
        cyc("dm_steal", C_FRZ, 0);
        clr_in(); req(2, 0);                                 cyc("dm_gnt", C_GNT, 0);
        clr_in();                                            cyc("idle1", C_NONE, 0);

        // Request dropping in WAIT restarts the starvation count.
        req(2, 1);                                           cyc("dr_w1", C_NONE, 0);
        cyc("dr_w2", C_NONE, 0);
        clr_in();                                            cyc("dr_drop", C_NONE, 0);
        req(2, 1);
        for (int i = 0; i < 4; i++) cyc("dr_wait", C_NONE, 0);
        cyc("dr_steal", C_FRZ, 0);
        clr_in(); req(2, 0);                                 cyc("dr_gnt", C_GNT, 0);
        clr_in();                                            cyc("idle2", C_NONE, 0);

        // Reset landing on the STEAL cycle.
        i_div_issue = 1; i_div_rd = 11;                      cyc("iss11", C_NONE, 0);
        clr_in(); req(12, 1);
        for (int i = 0; i < 4; i++) cyc("rs_wait", C_NONE, pb(11));
        i_reset = 1'b1;                                      cyc("rs_steal", C_NONE, pb(11));
        i_reset = 1'b0;                                      cyc("rs_after", C_NONE, 0);
        clr_in();                                            cyc("rs_idle", C_NONE, 0);

        waited = 0;
        while (sb.size() > 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        if (sb.size() > 0) check_val("drain", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
